aurora_tx_stream_ctrl: RTL and testbench



---
 rtl/aurora_tx_stream_ctrl.sv | 116 +++++++++++
 tb/tb_aurora_tx_stream_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/aurora_tx_stream_ctrl.sv
// Streams words from a standard-read FIFO onto the Aurora LocalLink TX interface.
// Optional beat counter enabled by defining AURORA_TX_WORD_COUNT_EN.
module aurora_tx_stream_ctrl #(
  parameter int WIDTH          = 32,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             link_active,
  input  logic [WIDTH-1:0] fifo_data_i,
  input  logic             fifo_empty_i,
  output logic             fifo_read_o,
  output logic [WIDTH-1:0] tx_d,
  output logic             tx_src_rdy_n,
  input  logic             tx_dst_rdy_n,
  output logic [31:0]      word_count
);

  typedef enum logic [1:0] {S_DOWN, S_HOLDOFF, S_RUN} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF_CYCLES - 1);

  state_t           state;
  logic [7:0]       hold_cnt;
  logic [1:0]       count;
  logic             rd_pending;
  logic [WIDTH-1:0] tail_q;

  logic             accepted;
  logic [2:0]       occ_after;
  logic [WIDTH-1:0] nxt_head;
  logic [WIDTH-1:0] nxt_tail;
  logic [1:0]       nxt_count;

  assign accepted  = ~tx_src_rdy_n & ~tx_dst_rdy_n;
  // Occupancy once this cycle's beat leaves and the in-flight word lands.
  assign occ_after = {1'b0, count} + {2'b00, rd_pending} - {2'b00, accepted};

  assign fifo_read_o = (state == S_RUN) & link_active & ~fifo_empty_i & (occ_after < 3'd2);

  // tx_d is the buffer head; tail_q holds the second entry.
  // NOTE: always_comb uses blocking assignments with a default for every signal first,
  // so later statements see earlier results and no latch can be inferred.
  always_comb begin
    nxt_head  = tx_d;
    nxt_tail  = tail_q;
    nxt_count = count;
    if (accepted) begin
      nxt_head  = tail_q;
      nxt_count = count - 2'd1;
    end
    if (rd_pending) begin
      if (nxt_count == 2'd0) nxt_head = fifo_data_i;
      else                   nxt_tail = fifo_data_i;
      nxt_count = nxt_count + 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_DOWN;
      hold_cnt     <= 8'd0;
      count        <= 2'd0;
      rd_pending   <= 1'b0;
      tx_src_rdy_n <= 1'b1;
      tx_d         <= '0;
    end else begin
      case (state)
        S_DOWN: begin
          hold_cnt <= 8'd0;
          if (link_active) state <= S_HOLDOFF;
        end
        S_HOLDOFF: begin
          if (hold_cnt == HOLD_LAST) state <= S_RUN;
          else                       hold_cnt <= hold_cnt + 8'd1;
        end
        S_RUN:   state <= S_RUN;
        default: state <= S_DOWN;
      endcase

      if (!link_active) begin
        // Flush: buffered and in-flight words are dropped, not re-read.
        state        <= S_DOWN;
        count        <= 2'd0;
        rd_pending   <= 1'b0;
        tx_src_rdy_n <= 1'b1;
      end else begin
        count        <= nxt_count;
        rd_pending   <= fifo_read_o;
        tx_d         <= nxt_head;
        tx_src_rdy_n <= ~((state == S_RUN) && (nxt_count != 2'd0));
      end
    end
  end

  // NOTE: the tail entry is data storage qualified by count, so it carries no reset.
  always_ff @(posedge clk) begin
    tail_q <= nxt_tail;
  end

`ifdef AURORA_TX_WORD_COUNT_EN
  logic [31:0] word_count_q;

  always_ff @(posedge clk) begin
    if (rst)           word_count_q <= 32'd0;
    else if (accepted) word_count_q <= word_count_q + 32'd1;
  end

  assign word_count = word_count_q;
`else
  assign word_count = 32'd0;
`endif

endmodule

// File: tb/tb_aurora_tx_stream_ctrl.sv
// Randomised self-checking bench for aurora_tx_stream_ctrl: a FIFO model feeds the DUT,
// and a queue of read-but-unsent words serves as the reference for the TX stream.
module tb_aurora_tx_stream_ctrl;
  localparam int W = 32;
  localparam int H = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          link_active;
  logic [W-1:0]  fifo_data_i;
  logic          fifo_empty_i;
  logic          fifo_read_o;
  logic [W-1:0]  tx_d;
  logic          tx_src_rdy_n;
  logic          tx_dst_rdy_n;
  logic [31:0]   word_count;

  aurora_tx_stream_ctrl #(.WIDTH(W), .HOLDOFF_CYCLES(H)) dut (
    .clk          (clk),
    .rst          (rst),
    .link_active  (link_active),
    .fifo_data_i  (fifo_data_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_read_o  (fifo_read_o),
    .tx_d         (tx_d),
    .tx_src_rdy_n (tx_src_rdy_n),
    .tx_dst_rdy_n (tx_dst_rdy_n),
    .word_count   (word_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  int          up_cnt = 0;
  bit          prev_link = 0, prev_rd = 0, prev_stall = 0;
  logic [31:0] prev_d = '0;
  int          n_acc = 0;
  int          dst_mode = 0;   // 0 always ready, 1 never ready, 2 random
  bit          link_drv = 0;
  bit          last_acc = 0;
  int          cyc = 0;
  int          first_rd_up = -1, first_src_up = -1;
  int          ph_first = -1, ph_last = -1;
  bit          got_first = 0;
  logic [31:0] first_word = '0;

  function automatic logic [31:0] exp_wc(int n);
`ifdef AURORA_TX_WORD_COUNT_EN
    return 32'(n);
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at posedge+1, sample and score at negedge.
  task automatic cycle();
    logic        rd, acc;
    logic [31:0] d, rd_word;
    link_active  = link_drv;
    fifo_empty_i = (fifo_q.size() == 0);
    tx_dst_rdy_n = (dst_mode == 0) ? 1'b0 : (dst_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    @(negedge clk);
    cyc++;
    rd      = fifo_read_o;
    d       = tx_d;
    acc     = !tx_src_rdy_n && !tx_dst_rdy_n;
    rd_word = $urandom();
    if (link_active) up_cnt = prev_link ? up_cnt + 1 : 0;
    check("rd_gate", 32'(rd & !(link_active && !fifo_empty_i && up_cnt >= H + 1)), 0);
    if (!prev_link) check("src_after_down", 32'(tx_src_rdy_n), 1);
    if (prev_stall) begin
      check("stall_data", d, prev_d);
      check("stall_src", 32'(tx_src_rdy_n), 0);
    end
    check("occupancy", 32'((exp_q.size() - int'(prev_rd)) <= 2), 1);
    if (acc) begin
      if (exp_q.size() == 0) check("spurious_beat", 1, 0);
      else check("beat_data", d, exp_q.pop_front());
      n_acc++;
      if (ph_first < 0) ph_first = cyc;
      ph_last = cyc;
      if (!got_first) begin got_first = 1; first_word = d; end
    end
    if (rd && fifo_q.size() > 0) begin
      rd_word = fifo_q.pop_front();
      exp_q.push_back(rd_word);
    end
    if (!link_active) exp_q.delete();
    if (rd && first_rd_up < 0) first_rd_up = up_cnt;
    if (!tx_src_rdy_n && first_src_up < 0) first_src_up = up_cnt;
    prev_stall = !tx_src_rdy_n && tx_dst_rdy_n && link_active;
    prev_d     = d;
    prev_rd    = rd;
    prev_link  = link_active;
    last_acc   = acc;
    @(posedge clk);
    #1;
    fifo_data_i = rd_word;
  endtask

  task automatic wait_idle(int budget);
    int k = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && k < budget) begin
      cycle();
      k++;
    end
    check("drain_timeout", 32'(k < budget), 1);
    repeat (3) cycle();
  endtask

  initial begin
    int base, lat;
    logic [31:0] next_word;
    rst = 1'b1; link_active = 1'b0; fifo_empty_i = 1'b1;
    tx_dst_rdy_n = 1'b1; fifo_data_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 1; i <= 100; i++) fifo_q.push_back(32'(i));
    fifo_empty_i = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_read", 32'(fifo_read_o), 0);
    check("rst_src", 32'(tx_src_rdy_n), 1);
    check("rst_tx_d", tx_d, 0);
    check("rst_word_count", word_count, 0);
    @(posedge clk);
    #1;
    repeat (2) cycle();

    // Link up, holdoff, then 100 back-to-back beats
    link_drv = 1; ph_first = -1; base = n_acc;
    wait_idle(400);
    check("first_read_cycle", 32'(first_rd_up), 32'(H + 1));
    check("first_src_cycle", 32'(first_src_up), 32'(H + 3));
    check("stream_beats", 32'(n_acc - base), 100);
    check("stream_span", 32'(ph_last - ph_first + 1), 100);
    check("word_count_100", word_count, exp_wc(n_acc));

    // Random back-pressure
    dst_mode = 2; base = n_acc;
    for (int i = 0; i < 200; i++) fifo_q.push_back($urandom());
    wait_idle(3000);
    check("random_beats", 32'(n_acc - base), 200);
    check("word_count_rand", word_count, exp_wc(n_acc));

    // FIFO runs dry, then refills
    dst_mode = 0;
    for (int i = 0; i < 5; i++) fifo_q.push_back($urandom());
    wait_idle(50);
    repeat (4) cycle();
    for (int i = 0; i < 5; i++) fifo_q.push_back($urandom());
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (last_acc && lat < 0) lat = k;
    end
    check("refill_latency", 32'(lat), 2);
    wait_idle(50);

    // Link drop mid-stream, glitch during holdoff, relink
    dst_mode = 2;
    for (int i = 0; i < 30; i++) fifo_q.push_back($urandom());
    repeat (10) cycle();
    link_drv = 0;
    cycle();
    next_word = fifo_q[0];
    cycle();
    link_drv = 1;
    repeat (5) cycle();
    link_drv = 0;
    cycle();
    link_drv = 1; first_rd_up = -1; got_first = 0;
    wait_idle(600);
    check("relink_first_read", 32'(first_rd_up), 32'(H + 1));
    check("relink_got_beat", 32'(got_first), 1);
    check("relink_next_word", first_word, next_word);
    check("word_count_final", word_count, exp_wc(n_acc));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
